exe_pipe: RTL
=============

# exe_pipe

Parametrised, pipelined RV32I/M execute stage. It computes the ALU result, the PC+immediate target, the jump address and the branch decision for one instruction, plus iterative multiplication (MUL/MULH/MULHSU/MULHU). Results are delivered through a registered valid/ready output. It sits between decode and memory in the pipelined core, replacing the single-cycle combinational execute stage.

## Interface
Parameters:
- XLEN, 32: datapath width; the multiplier runs XLEN iterations.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_flush  in  1  discard the in-flight op and the output register.
- i_valid  in  1  upstream op valid.
- o_ready  out  1  stage accepts an op on this edge.
- i_alu_input_sel  in  1  1 selects i_immed as ALU op2; 0 selects rs2.
- i_alu_op_sel  in  3  ALU operation.
- i_alu_sub_sel, i_alu_sign_sel, i_alu_arith_sel  in  1 each  ALU modifiers: sub, unsigned, arithmetic shift.
- i_mul_sel  in  1  op is an M-extension multiply; i_funct3[1:0] selects the variant.
- i_branch_sel  in  1  op is a conditional branch.
- i_jump_sel  in  1  op is an unconditional jump.
- i_jump_type_sel  in  1  1 selects JALR (ALU target); 0 selects PC+imm.
- i_funct3  in  3  branch condition or multiply variant.
- i_rs1_data, i_rs2_data, i_immed, i_pc  in  XLEN each  operands.
- o_valid  out  1  output register holds a result.
- i_ready  in  1  downstream consumes on this edge when o_valid=1.
- o_result  out  XLEN  ALU or multiply result.
- o_pc_immed  out  XLEN  i_pc+i_immed, modulo 2^XLEN.
- o_jump_addr  out  XLEN  jump or branch target.
- o_branch_taken  out  1  control transfer taken.

## Operation
- Branch compare always uses rs1 against rs2, independent of i_alu_input_sel. Decode sets the ALU for compare.
- Branch conditions by i_funct3:
  - 000 eq; 001 !eq; 100 slt; 101 !slt; 110 sltu; 111 !sltu.
  - Any other funct3 is not taken.
- o_branch_taken = i_jump_sel | (i_branch_sel & cond).
- o_jump_addr:
  - i_jump_type_sel=1: {alu_result[XLEN-1:1],1'b0}.
  - i_jump_type_sel=0: pc+imm.
- Multiply: sign-correct the operand magnitudes per variant, run XLEN shift-add steps on an unsigned 2·XLEN accumulator, then negate if the operand signs differ.
  - MUL (00) returns the low half.
  - MULH (01), MULHSU (10) and MULHU (11) return the high half.
- FSM has three states:
  - IDLE: accepts ops.
  - MUL: iterating; counter runs 0..XLEN-1.
  - DONE: waits for a free output register.
- Transitions:
  - IDLE→MUL on accept with i_mul_sel.
  - MUL→DONE after the XLEN-th step.
  - DONE→IDLE when the output register is loaded.
- o_ready = (state==IDLE) & (!o_valid | i_ready) & !i_flush.
- A non-multiply op loads the output register on its accept edge.
- Output register: loaded when free or consumed on the same edge. Held stable while o_valid=1 and i_ready=0.

## Timing
- Reset: the asynchronous i_rst=1 forces all of the following to 0 immediately, with no wait for a clock edge:
  - o_valid, o_result, o_pc_immed, o_jump_addr, o_branch_taken;
  - state = IDLE, counter = 0.
- o_ready is 1 once i_rst is released.
- ALU, branch and jump latency: result valid the cycle after the accept edge (1 cycle).
- Multiply: accept at edge E, iterations on edges E+1..E+XLEN, load at edge E+XLEN+1 if the output is free.
  - o_ready=0 from after edge E until the load.
- Simultaneous consume and accept: the output register is reloaded with no bubble.
- Flush: on the edge where it is sampled, o_valid←0 and state←IDLE. An i_valid presented in the same cycle is dropped.
- Reset in mid-multiply aborts with no output.
- Counter wrap is not reachable; the counter is cleared on entry to MUL.

## Structure
- Package exe_pkg holds:
  - the state enum (IDLE, MUL, DONE);
  - the funct3 branch codes and multiply variant codes.
- Sub-module exe_mul_iter: the iterative multiplier with a start/done handshake and a 2·XLEN accumulator, parametrised by XLEN.
- The existing alu module is instantiated for ALU operations and for eq/slt.

## Test plan
- ADD, rs1=5, imm=7, input_sel=1 → o_valid=1 the next cycle, o_result=12.
- BLT, rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 → taken=1, jump_addr=0x120. The same operands with BLTU → taken=0.
- JALR, rs1=0x1003, imm=0 → jump_addr=0x1002, taken=1.
- MULH, 0x80000000×2 → o_result=0xFFFFFFFF, o_ready low for 33 cycles; MUL with the same operands → 0.
- Backpressure: i_ready=0 for 5 cycles → result held and o_ready=0; on release, results drain in order with no loss.
- Flush at MUL iteration 10 → no o_valid, o_ready=1 next cycle, and a following ADD is correct. i_rst mid-op → all outputs 0 with no clock edge.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared types and encodings for the execute stage: FSM states, ALU op codes,
// branch conditions and multiply variants.
package exe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SLL  = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b010;
   localparam logic [2:0] ALU_SLTU = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_SR   = 3'b101;
   localparam logic [2:0] ALU_OR   = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [1:0] MV_MUL    = 2'b00;
   localparam logic [1:0] MV_MULH   = 2'b01;
   localparam logic [1:0] MV_MULHSU = 2'b10;
   localparam logic [1:0] MV_MULHU  = 2'b11;

   // lt must already carry the signedness implied by f3[1]
   function automatic logic branch_cond(input logic [2:0] f3, input logic eq, input logic lt);
      logic c;
      case (f3)
         F3_BEQ:  c = eq;
         F3_BNE:  c = !eq;
         F3_BLT:  c = lt;
         F3_BGE:  c = !lt;
         F3_BLTU: c = lt;
         F3_BGEU: c = !lt;
         default: c = 1'b0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu.sv
// Integer ALU for RV32I register/immediate ops, with a separate rs1/rs2
// comparator used for branch conditions.
module alu
   import exe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_op1,
   input  logic [XLEN-1:0] i_op2,
   input  logic [2:0]      i_op_sel,
   input  logic            i_sub_sel,
   input  logic            i_sign_sel,
   input  logic            i_arith_sel,
   input  logic [XLEN-1:0] i_cmp_a,
   input  logic [XLEN-1:0] i_cmp_b,
   input  logic            i_cmp_unsigned,
   output logic [XLEN-1:0] o_result,
   output logic            o_eq,
   output logic            o_lt
);

   localparam int SHW = $clog2(XLEN);

   logic signed [XLEN-1:0] op1_s, op2_s, sra_s, cmp_a_s, cmp_b_s;
   logic        [SHW-1:0]  shamt;
   logic                   slt, ult;

   assign op1_s   = i_op1;
   assign op2_s   = i_op2;
   assign cmp_a_s = i_cmp_a;
   assign cmp_b_s = i_cmp_b;
   assign shamt   = i_op2[SHW-1:0];
   assign sra_s   = op1_s >>> shamt;
   assign slt     = op1_s < op2_s;
   assign ult     = i_op1 < i_op2;

   always_comb begin
      o_result = '0;
      case (i_op_sel)
         ALU_ADD:  o_result = i_sub_sel ? (i_op1 - i_op2) : (i_op1 + i_op2);
         ALU_SLL:  o_result = i_op1 << shamt;
         ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, (i_sign_sel ? ult : slt)};
         ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, ult};
         ALU_XOR:  o_result = i_op1 ^ i_op2;
         ALU_SR:   o_result = i_arith_sel ? sra_s : (i_op1 >> shamt);
         ALU_OR:   o_result = i_op1 | i_op2;
         ALU_AND:  o_result = i_op1 & i_op2;
         default:  o_result = '0;
      endcase
   end

   assign o_eq = (i_cmp_a == i_cmp_b);
   assign o_lt = i_cmp_unsigned ? (i_cmp_a < i_cmp_b) : (cmp_a_s < cmp_b_s);

endmodule

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier: one step per cycle over XLEN cycles on
// operand magnitudes, sign restored at the output.
module exe_mul_iter
   import exe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_abort,
   input  logic            i_start,
   input  logic [1:0]      i_variant,
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   output logic            o_last,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   localparam int CW = $clog2(XLEN);

   logic              busy_q, busy_d, done_q, done_d, neg_q, neg_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d, acc_step, product;
   logic [XLEN-1:0]   mcand_q, mcand_d, mag_a, mag_b;
   logic [1:0]        var_q, var_d;
   logic [XLEN:0]     sum;
   logic              a_neg, b_neg;

   assign a_neg = (i_variant != MV_MULHU) & i_op_a[XLEN-1];
   assign b_neg = (i_variant != MV_MULHSU) & (i_variant != MV_MULHU) & i_op_b[XLEN-1];
   assign mag_a = a_neg ? -i_op_a : i_op_a;
   assign mag_b = b_neg ? -i_op_b : i_op_b;

   // Multiplier sits in the low half and shifts out as the product grows in
   assign sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mcand_q : {XLEN{1'b0}})};
   assign acc_step = {sum, acc_q[XLEN-1:1]};
   assign o_last   = busy_q & (cnt_q == CW'(XLEN-1));

   always_comb begin
      busy_d  = busy_q;
      done_d  = done_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      neg_d   = neg_q;
      var_d   = var_q;
      if (i_abort) begin
         busy_d = 1'b0;
         done_d = 1'b0;
      end else if (i_start) begin
         busy_d  = 1'b1;
         done_d  = 1'b0;
         cnt_d   = '0;
         acc_d   = {{XLEN{1'b0}}, mag_b};
         mcand_d = mag_a;
         neg_d   = a_neg ^ b_neg;
         var_d   = i_variant;
      end else if (busy_q) begin
         acc_d = acc_step;
         cnt_d = o_last ? '0 : cnt_q + CW'(1);
         if (o_last) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         neg_q   <= 1'b0;
         var_q   <= MV_MUL;
      end else begin
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         neg_q   <= neg_d;
         var_q   <= var_d;
      end
   end

   assign product  = neg_q ? -acc_q : acc_q;
   assign o_result = (var_q == MV_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
   assign o_done   = done_q;

endmodule

// File: rtl/exe_pipe.sv
// Pipelined RV32I/M execute stage: ALU, branch/jump resolution and iterative
// multiply behind a registered valid/ready output.
module exe_pipe
   import exe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic            i_alu_input_sel,
   input  logic [2:0]      i_alu_op_sel,
   input  logic            i_alu_sub_sel,
   input  logic            i_alu_sign_sel,
   input  logic            i_alu_arith_sel,
   input  logic            i_mul_sel,
   input  logic            i_branch_sel,
   input  logic            i_jump_sel,
   input  logic            i_jump_type_sel,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   input  logic [XLEN-1:0] i_immed,
   input  logic [XLEN-1:0] i_pc,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_result,
   output logic [XLEN-1:0] o_pc_immed,
   output logic [XLEN-1:0] o_jump_addr,
   output logic            o_branch_taken
);

   state_e          state_q, state_d;
   logic            valid_q, valid_d, taken_q, taken_d;
   logic [XLEN-1:0] result_q, result_d, pc_immed_q, pc_immed_d;
   logic [XLEN-1:0] jump_addr_q, jump_addr_d, pc_hold_q, pc_hold_d;
   logic [XLEN-1:0] op2, alu_result, mul_result, pc_imm, jump_target;
   logic            cmp_eq, cmp_lt, taken, out_free, ready, accept;
   logic            mul_start, alu_load, mul_load, mul_last, mul_done;

   assign op2 = i_alu_input_sel ? i_immed : i_rs2_data;

   alu #(.XLEN(XLEN)) u_alu (
      .i_op1          (i_rs1_data),
      .i_op2          (op2),
      .i_op_sel       (i_alu_op_sel),
      .i_sub_sel      (i_alu_sub_sel),
      .i_sign_sel     (i_alu_sign_sel),
      .i_arith_sel    (i_alu_arith_sel),
      .i_cmp_a        (i_rs1_data),
      .i_cmp_b        (i_rs2_data),
      .i_cmp_unsigned (i_funct3[1]),
      .o_result       (alu_result),
      .o_eq           (cmp_eq),
      .o_lt           (cmp_lt)
   );

   exe_mul_iter #(.XLEN(XLEN)) u_mul (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_abort   (i_flush),
      .i_start   (mul_start),
      .i_variant (i_funct3[1:0]),
      .i_op_a    (i_rs1_data),
      .i_op_b    (i_rs2_data),
      .o_last    (mul_last),
      .o_done    (mul_done),
      .o_result  (mul_result)
   );

   assign pc_imm      = i_pc + i_immed;
   assign taken       = i_jump_sel | (i_branch_sel & branch_cond(i_funct3, cmp_eq, cmp_lt));
   assign jump_target = i_jump_type_sel ? {alu_result[XLEN-1:1], 1'b0} : pc_imm;
   assign out_free    = !valid_q | i_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (i_flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL:  if (mul_last)  state_d = ST_DONE;
            ST_DONE: if (mul_load)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      ready     = (state_q == ST_IDLE) & out_free & !i_flush;
      accept    = i_valid & ready;
      mul_start = accept & i_mul_sel;
      alu_load  = accept & !i_mul_sel;
      mul_load  = (state_q == ST_DONE) & mul_done & out_free & !i_flush;
   end

   // Output register: reloads on the same edge it is consumed, so no bubble
   always_comb begin
      valid_d     = valid_q;
      result_d    = result_q;
      pc_immed_d  = pc_immed_q;
      jump_addr_d = jump_addr_q;
      taken_d     = taken_q;
      pc_hold_d   = mul_start ? pc_imm : pc_hold_q;
      if (alu_load) begin
         result_d    = alu_result;
         pc_immed_d  = pc_imm;
         jump_addr_d = jump_target;
         taken_d     = taken;
      end else if (mul_load) begin
         result_d    = mul_result;
         pc_immed_d  = pc_hold_q;
         jump_addr_d = pc_hold_q;
         taken_d     = 1'b0;
      end
      if (i_flush)                   valid_d = 1'b0;
      else if (alu_load | mul_load)  valid_d = 1'b1;
      else if (i_ready)              valid_d = 1'b0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q     <= 1'b0;
         result_q    <= '0;
         pc_immed_q  <= '0;
         jump_addr_q <= '0;
         taken_q     <= 1'b0;
         pc_hold_q   <= '0;
      end else begin
         valid_q     <= valid_d;
         result_q    <= result_d;
         pc_immed_q  <= pc_immed_d;
         jump_addr_q <= jump_addr_d;
         taken_q     <= taken_d;
         pc_hold_q   <= pc_hold_d;
      end
   end

   assign o_ready        = ready;
   assign o_valid        = valid_q;
   assign o_result       = result_q;
   assign o_pc_immed     = pc_immed_q;
   assign o_jump_addr    = jump_addr_q;
   assign o_branch_taken = taken_q;

endmodule
